// File: rtl/jogo_memoria_parametrizado_if.sv
// jogo_memoria_parametrizado_if: player/board-side signals of the memory game
interface jogo_memoria_parametrizado_if #(
  parameter int N_BOTOES    = 4,
  parameter int MAX_RODADAS = 16
);
  localparam int RW = $clog2(MAX_RODADAS) + 1;
  logic                jogar;
  logic                dificuldade;
  logic [N_BOTOES-1:0] botoes;
  logic [N_BOTOES-1:0] leds;
  logic                ganhou;
  logic                perdeu;
  logic                pronto;
  logic                db_timeout;
  logic [3:0]          db_estado;
  logic [RW-1:0]       db_rodada;
  modport master (
    output jogar, dificuldade, botoes,
    input  leds, ganhou, perdeu, pronto, db_timeout, db_estado, db_rodada
  );
  modport slave (
    input  jogar, dificuldade, botoes,
    output leds, ganhou, perdeu, pronto, db_timeout, db_estado, db_rodada
  );
endinterface

// File: rtl/jogo_memoria_parametrizado.sv
// jogo_memoria_parametrizado: LFSR-driven sequence-memory game with playback, timeout and difficulty
module jogo_memoria_parametrizado #(
  parameter int          N_BOTOES       = 4,
  parameter int          MAX_RODADAS    = 16,
  parameter int          TIMEOUT_CICLOS = 5000,
  parameter int          TEMPO_LED      = 1000,
  parameter int          TEMPO_APAGADO  = 500,
  parameter logic [15:0] SEMENTE        = 16'hACE1
) (
  input logic clock,
  input logic reset,
  jogo_memoria_parametrizado_if.slave io
);
  localparam int RW = $clog2(MAX_RODADAS) + 1;
  localparam int AW = $clog2(MAX_RODADAS);
  localparam int TM = TIMEOUT_CICLOS > TEMPO_LED
                    ? (TIMEOUT_CICLOS > TEMPO_APAGADO ? TIMEOUT_CICLOS : TEMPO_APAGADO)
                    : (TEMPO_LED > TEMPO_APAGADO ? TEMPO_LED : TEMPO_APAGADO);
  localparam int CW = $clog2(TM + 1);
  typedef enum logic [3:0] {
    INICIAL  = 4'h0, PREPARA  = 4'h1, GERA    = 4'h2, MOSTRA  = 4'h3,
    APAGA    = 4'h4, ESPERA   = 4'h5, REGISTRA = 4'h6, COMPARA = 4'h7,
    PROXIMA  = 4'h8, GANHOU   = 4'hA, PERDEU  = 4'hE, ESGOTOU = 4'hF
  } estado_t;
  estado_t             estado;
  logic [15:0]         lfsr;
  logic [N_BOTOES-1:0] ram [MAX_RODADAS];
  logic [N_BOTOES-1:0] jog, prev, novo;
  logic [RW-1:0]       rodada, limite, ultimo;
  logic [AW-1:0]       endereco;
  logic [CW-1:0]       cnt;
  logic                jogada, fb, fim_seq;
  assign jogada  = |io.botoes && !(|prev);
  assign ultimo  = rodada - RW'(1);
  assign fim_seq = RW'(endereco) == ultimo;
  assign fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign novo    = N_BOTOES'(1) << (lfsr % 16'(N_BOTOES));
  // sequence storage is never reset; only written in GERA
  always_ff @(posedge clock)
    if (estado == GERA) ram[rodada[AW-1:0]] <= novo;
  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= INICIAL;
      lfsr     <= SEMENTE;
      rodada   <= '0;
      limite   <= '0;
      endereco <= '0;
      cnt      <= '0;
      jog      <= '0;
      prev     <= '0;
    end else begin
      prev <= io.botoes;
      case (estado)
        INICIAL, GANHOU, PERDEU, ESGOTOU:
          if (io.jogar) begin
            limite <= io.dificuldade ? RW'(MAX_RODADAS) : RW'(MAX_RODADAS / 2);
            estado <= PREPARA;
          end
        PREPARA: begin
          rodada <= '0;
          estado <= GERA;
        end
        GERA: begin
          lfsr     <= {lfsr[14:0], fb};
          rodada   <= rodada + 1'b1;
          endereco <= '0;
          cnt      <= '0;
          estado   <= MOSTRA;
        end
        MOSTRA:
          if (cnt == CW'(TEMPO_LED - 1)) begin
            cnt    <= '0;
            estado <= APAGA;
          end else cnt <= cnt + 1'b1;
        APAGA:
          if (cnt == CW'(TEMPO_APAGADO - 1)) begin
            cnt      <= '0;
            endereco <= fim_seq ? '0 : endereco + 1'b1;
            estado   <= fim_seq ? ESPERA : MOSTRA;
          end else cnt <= cnt + 1'b1;
        // a fresh press beats the timeout on the same cycle
        ESPERA:
          if (jogada) begin
            jog    <= io.botoes;
            estado <= REGISTRA;
          end else if (cnt == CW'(TIMEOUT_CICLOS - 1)) estado <= ESGOTOU;
          else cnt <= cnt + 1'b1;
        REGISTRA: estado <= COMPARA;
        COMPARA:
          if (jog != ram[endereco]) estado <= PERDEU;
          else if (fim_seq) estado <= PROXIMA;
          else begin
            endereco <= endereco + 1'b1;
            cnt      <= '0;
            estado   <= ESPERA;
          end
        PROXIMA: estado <= rodada == limite ? GANHOU : GERA;
        default: estado <= INICIAL;
      endcase
    end
  end
  assign io.leds       = estado == MOSTRA ? ram[endereco] : estado == REGISTRA ? jog : '0;
  assign io.ganhou     = estado == GANHOU;
  assign io.perdeu     = estado == PERDEU || estado == ESGOTOU;
  assign io.pronto     = estado == GANHOU || estado == PERDEU || estado == ESGOTOU;
  assign io.db_timeout = estado == ESGOTOU;
  assign io.db_estado  = estado;
  assign io.db_rodada  = rodada;
endmodule

// File: tb/tb_jogo_memoria_parametrizado.sv
// tb_jogo_memoria_parametrizado: table-driven games against a sequence model with random press timing
module tb_jogo_memoria_parametrizado;
  localparam int N = 4, MR = 4, TO = 20, TL = 4, TA = 2;
  typedef struct {
    bit       dif;
    int       wr;
    int       modo;
    bit [3:0] est;
    bit       g, p, pr, t;
    int       rod;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0, fails = 0;
  int   ml;
  int   seq [MR];
  vec_t tab [7];
  vec_t vr;
  always #5 clk = ~clk;
  jogo_memoria_parametrizado_if #(.N_BOTOES(N), .MAX_RODADAS(MR)) io ();
  jogo_memoria_parametrizado #(
    .N_BOTOES(N), .MAX_RODADAS(MR), .TIMEOUT_CICLOS(TO),
    .TEMPO_LED(TL), .TEMPO_APAGADO(TA), .SEMENTE(16'hACE1)
  ) dut (.clock(clk), .reset(rst), .io(io));
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic wait_st(input int code, input int budget);
    int n;
    n = 0;
    while (int'(io.db_estado) != code && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (int'(io.db_estado) != code) begin
      tests++;
      fails++;
      $display("FAIL wait_state: got %0h expected %0h", io.db_estado, code);
    end
  endtask
  // next sequence element: one-hot of LFSR mod N, then one Fibonacci step
  task automatic gen(output int e);
    e  = 1 << (ml % N);
    ml = ((ml << 1) | (((ml >> 15) ^ (ml >> 13) ^ (ml >> 12) ^ (ml >> 10)) & 1)) & 'hFFFF;
  endtask
  function automatic int pk_dut();
    return int'({io.ganhou, io.perdeu, io.pronto, io.db_timeout, io.db_estado, io.db_rodada});
  endfunction
  task automatic play(input vec_t v);
    int lim, val, k, nerr, n;
    bit done;
    done = 0;
    io.jogar = 1'b1;
    io.dificuldade = v.dif;
    @(negedge clk);
    io.jogar = 1'b0;
    chk("prepara", int'(io.db_estado), 1);
    lim = v.dif ? MR : MR / 2;
    for (int r = 1; r <= lim; r++) begin
      gen(seq[r-1]);
      wait_st(3, 20);
      chk("rodada", int'(io.db_rodada), r);
      nerr = 0;
      for (int s = 0; s < r * (TL + TA); s++) begin
        val = (s % (TL + TA) < TL) ? seq[s / (TL + TA)] : 0;
        if (int'(io.leds) != val) nerr++;
        @(negedge clk);
      end
      chk("playback_errs", nerr, 0);
      chk("espera", int'(io.db_estado), 5);
      for (int i = 0; i < r; i++) begin
        wait_st(5, 10);
        if (v.modo == 3 && r == v.wr) begin
          n = 0;
          while (int'(io.db_estado) == 5 && n < 40) begin
            n++;
            @(negedge clk);
          end
          chk("timeout_cycles", n, TO);
          done = 1;
          break;
        end
        repeat ($urandom_range(8, 1)) @(negedge clk);
        val = seq[i];
        if (r == v.wr && i == 0 && v.modo == 1) begin
          k   = $urandom_range(3, 1);
          val = ((val << k) | (val >> (N - k))) & 'hF;
        end
        if (r == v.wr && i == 0 && v.modo == 2) val = 'b0011;
        io.botoes = N'(val);
        @(negedge clk);
        chk("registra", int'(io.db_estado), 6);
        chk("echo", int'(io.leds), val);
        if ($urandom_range(1, 0) == 1) @(negedge clk);
        io.botoes = '0;
        if (val != seq[i]) begin
          done = 1;
          break;
        end
      end
      if (done) break;
    end
    wait_st(int'(v.est), 30);
    chk("final", pk_dut(), int'({v.g, v.p, v.pr, v.t, v.est, 3'(v.rod)}));
    repeat (3) @(negedge clk);
    chk("hold", int'(io.db_estado), int'(v.est));
  endtask
  initial begin
    tab[0] = '{1'b1, 0, 0, 4'hA, 1'b1, 1'b0, 1'b1, 1'b0, 4};
    tab[1] = '{1'b0, 0, 0, 4'hA, 1'b1, 1'b0, 1'b1, 1'b0, 2};
    tab[2] = '{1'b1, 1, 1, 4'hE, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    tab[3] = '{1'b1, 1, 3, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 1};
    tab[4] = '{1'b1, 2, 2, 4'hE, 1'b0, 1'b1, 1'b1, 1'b0, 2};
    tab[5] = '{1'b0, 2, 3, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 2};
    tab[6] = '{1'b1, 3, 1, 4'hE, 1'b0, 1'b1, 1'b1, 1'b0, 3};
    vr     = '{1'b0, 0, 0, 4'hA, 1'b1, 1'b0, 1'b1, 1'b0, 2};
    io.jogar = 1'b0;
    io.dificuldade = 1'b0;
    io.botoes = '0;
    ml = 'hACE1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_flags", pk_dut(), 0);
    chk("reset_leds", int'(io.leds), 0);
    for (int i = 0; i < 7; i++) play(tab[i]);
    // abort mid-playback: reset must land in INICIAL and reseed the LFSR
    io.jogar = 1'b1;
    io.dificuldade = 1'b1;
    @(negedge clk);
    io.jogar = 1'b0;
    wait_st(3, 10);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mostra_estado", int'(io.db_estado), 0);
    chk("rst_mostra_leds", int'(io.leds), 0);
    chk("rst_mostra_rodada", int'(io.db_rodada), 0);
    rst = 1'b0;
    ml = 'hACE1;
    @(negedge clk);
    play(vr);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
